// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } gnt_e;

   localparam int STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/mem_arb_latency_cnt.sv
// rtl/mem_arb_latency_cnt.sv - loadable down-counter with zero flag for the read latency wait
module mem_arb_latency_cnt #(
   parameter int MEM_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(MEM_LATENCY - 1);
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and sequencer for the shared external memory port
// Optional per-requester stall counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 12,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_ack,
   output logic [DATA_WIDTH-1:0] fetch_data,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  data_ack,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0] fetch_stall_cnt,
   output logic [STALL_CNT_WIDTH-1:0] data_stall_cnt
`endif
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_DONE  = DONE;

   logic [1:0] state;
   gnt_e       last_grant;
   gnt_e       owner;
   logic       gnt_fetch;
   logic       gnt_data;
   logic       lat_load;
   logic       lat_dec;
   logic       lat_zero;

   // Data wins a tie unless it won the previous transaction.
   always_comb begin
      gnt_fetch = 1'b0;
      gnt_data  = 1'b0;
      if (state == S_IDLE) begin
         if (fetch_req && data_req) begin
            if (last_grant == GNT_DATA) begin
               gnt_fetch = 1'b1;
            end else begin
               gnt_data = 1'b1;
            end
         end else begin
            gnt_fetch = fetch_req;
            gnt_data  = data_req;
         end
      end
   end

   assign lat_load = (state == S_ISSUE) && !mem_we;
   assign lat_dec  = (state == S_WAIT) && !lat_zero;

   mem_arb_latency_cnt #(
      .MEM_LATENCY(MEM_LATENCY)
   ) u_lat_cnt (
      .clk  (clk),
      .reset(reset),
      .load (lat_load),
      .dec  (lat_dec),
      .zero (lat_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= GNT_FETCH;
         owner      <= GNT_FETCH;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         fetch_ack  <= 1'b0;
         data_ack   <= 1'b0;
         fetch_data <= '0;
         data_rdata <= '0;
         busy       <= 1'b0;
      end else begin
         fetch_ack <= 1'b0;
         data_ack  <= 1'b0;
         mem_en    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt_fetch || gnt_data) begin
                  state  <= S_ISSUE;
                  busy   <= 1'b1;
                  mem_en <= 1'b1;
                  owner  <= gnt_data ? GNT_DATA : GNT_FETCH;
                  mem_we <= gnt_data && data_we;
                  if (gnt_data) begin
                     mem_addr  <= data_addr;
                     mem_wdata <= data_wdata;
                  end else begin
                     mem_addr <= fetch_addr;
                  end
               end
            end
            S_ISSUE: begin
               mem_we <= 1'b0;
               if (mem_we) begin
                  state <= S_DONE;
                  if (owner == GNT_DATA) begin
                     data_ack <= 1'b1;
                  end else begin
                     fetch_ack <= 1'b1;
                  end
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (lat_zero) begin
                  state <= S_DONE;
                  if (owner == GNT_DATA) begin
                     data_rdata <= mem_rdata;
                     data_ack   <= 1'b1;
                  end else begin
                     fetch_data <= mem_rdata;
                     fetch_ack  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               busy       <= 1'b0;
               last_grant <= owner;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic fetch_stall;
   logic data_stall;

   // In IDLE the owner register is stale, so the live grant decides who is waiting.
   assign fetch_stall = fetch_req && ((state == S_IDLE) ? !gnt_fetch : (owner != GNT_FETCH));
   assign data_stall  = data_req  && ((state == S_IDLE) ? !gnt_data  : (owner != GNT_DATA));

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_stall_cnt <= '0;
         data_stall_cnt  <= '0;
      end else begin
         if (fetch_stall && (fetch_stall_cnt != '1)) begin
            fetch_stall_cnt <= fetch_stall_cnt + STALL_CNT_WIDTH'(1);
         end
         if (data_stall && (data_stall_cnt != '1)) begin
            data_stall_cnt <= data_stall_cnt + STALL_CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic        fetch_req, fetch_ack, data_req, data_we, data_ack, mem_en, mem_we, busy;
   logic [11:0] fetch_addr, data_addr, mem_addr;
   logic [7:0]  fetch_data, data_wdata, data_rdata, mem_wdata, mem_rdata;

   logic        d3_fetch_req, d3_fetch_ack, d3_data_req, d3_data_we, d3_data_ack;
   logic        d3_mem_en, d3_mem_we, d3_busy;
   logic [11:0] d3_fetch_addr, d3_data_addr, d3_mem_addr;
   logic [7:0]  d3_fetch_data, d3_data_wdata, d3_data_rdata, d3_mem_wdata, d3_mem_rdata;

`ifdef MEM_ARB_STATS_EN
   logic [15:0] fetch_stall_cnt, data_stall_cnt, d3_fsc, d3_dsc;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .MEM_LATENCY(1)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_ack(data_ack), .data_rdata(data_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
      , .fetch_stall_cnt(fetch_stall_cnt), .data_stall_cnt(data_stall_cnt)
`endif
   );

   mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset),
      .fetch_req(d3_fetch_req), .fetch_addr(d3_fetch_addr), .fetch_ack(d3_fetch_ack),
      .fetch_data(d3_fetch_data),
      .data_req(d3_data_req), .data_we(d3_data_we), .data_addr(d3_data_addr),
      .data_wdata(d3_data_wdata), .data_ack(d3_data_ack), .data_rdata(d3_data_rdata),
      .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
      .mem_rdata(d3_mem_rdata), .busy(d3_busy)
`ifdef MEM_ARB_STATS_EN
      , .fetch_stall_cnt(d3_fsc), .data_stall_cnt(d3_dsc)
`endif
   );

   // Memory models: read data appears exactly MEM_LATENCY cycles after mem_en, zero otherwise.
   logic [7:0] mem1 [0:4095];
   logic [7:0] mem3 [0:4095];
   logic [7:0] p3_0, p3_1, p3_2;

   always @(posedge clk) begin
      if (reset) begin
         mem1[12'h010] <= 8'hA5;
         mem1[12'h020] <= 8'h5A;
         mem_rdata     <= 8'h00;
      end else begin
         if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
         mem_rdata <= (mem_en && !mem_we) ? mem1[mem_addr] : 8'h00;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         mem3[12'h123] <= 8'hC7;
         p3_0 <= 8'h00;
         p3_1 <= 8'h00;
         p3_2 <= 8'h00;
      end else begin
         p3_0 <= (d3_mem_en && !d3_mem_we) ? mem3[d3_mem_addr] : 8'h00;
         p3_1 <= p3_0;
         p3_2 <= p3_1;
      end
   end
   assign d3_mem_rdata = p3_2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_alt(input bit drop, input string tag);
      int seq [3];
      int when [3];
      int nack = 0;
      int dbl = 0;
      int consec = 0;
      logic prev_en = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fetch_addr = 12'h010;
      data_addr  = 12'h020;
      data_we    = 1'b0;
      fetch_req  = 1'b1;
      data_req   = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (fetch_ack && data_ack) dbl++;
         if (mem_en && prev_en) consec++;
         prev_en = mem_en;
         if ((data_ack || fetch_ack) && nack < 3) begin
            seq[nack]  = data_ack ? 1 : 2;
            when[nack] = c;
            nack++;
         end
         if (drop) begin
            data_req  = !data_ack;
            fetch_req = !fetch_ack;
         end
      end
      chk({tag, "_nack"}, 32'(nack), 32'd3);
      chk({tag, "_dbl_ack"}, 32'(dbl), 32'd0);
      chk({tag, "_en_consec"}, 32'(consec), 32'd0);
      if (nack == 3) begin
         chk({tag, "_order"}, 32'(seq[0] * 100 + seq[1] * 10 + seq[2]), 32'd121);
         chk({tag, "_when"}, 32'(when[0] * 100 + when[1] * 10 + when[2]), 32'd381);
      end
      fetch_req = 1'b0;
      data_req  = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      fetch_req = 1'b0; fetch_addr = '0; data_req = 1'b0; data_we = 1'b0;
      data_addr = '0; data_wdata = '0;
      d3_fetch_req = 1'b0; d3_fetch_addr = '0; d3_data_req = 1'b0; d3_data_we = 1'b0;
      d3_data_addr = '0; d3_data_wdata = '0;
      repeat (3) tick();
      chk("rst_ctrl", 32'({mem_en, mem_we, fetch_ack, data_ack, busy}), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_data", 32'({mem_wdata, fetch_data, data_rdata}), 32'd0);
      reset = 1'b0;
      tick();

      // Single fetch read, latency 1
      fetch_addr = 12'h010;
      fetch_req  = 1'b1;
      tick();
      chk("t1_mem_en", 32'({mem_en, mem_we, busy}), 32'b101);
      chk("t1_mem_addr", 32'(mem_addr), 32'h010);
      tick();
      chk("t1_en_drop", 32'({mem_en, fetch_ack}), 32'd0);
      tick();
      chk("t1_fetch_ack", 32'({fetch_ack, data_ack}), 32'b10);
      chk("t1_fetch_data", 32'(fetch_data), 32'hA5);
      fetch_req = 1'b0;
      tick();
      chk("t1_after", 32'({fetch_ack, busy}), 32'd0);
      chk("t1_data_held", 32'(fetch_data), 32'hA5);

      // Data write then readback at the top address
      data_we = 1'b1; data_addr = 12'hFFF; data_wdata = 8'h3C; data_req = 1'b1;
      tick();
      chk("t2_en_we", 32'({mem_en, mem_we}), 32'b11);
      chk("t2_addr_wdata", 32'({mem_addr, mem_wdata}), 32'hFFF3C);
      tick();
      chk("t2_wr_ack", 32'({data_ack, fetch_ack}), 32'b10);
      data_req = 1'b0;
      tick();
      chk("t2_wr_after", 32'({data_ack, busy}), 32'd0);
      data_we = 1'b0; data_req = 1'b1;
      tick();
      chk("t2_rd_en", 32'({mem_en, mem_we}), 32'b10);
      tick();
      tick();
      chk("t2_rd_ack", 32'(data_ack), 32'd1);
      chk("t2_rd_data", 32'(data_rdata), 32'h3C);
      data_req = 1'b0;
      tick();

      // Reset during WAIT abandons the read; the reissued request completes
      fetch_addr = 12'h010; fetch_req = 1'b1;
      tick();
      tick();
      chk("t5_in_wait", 32'({busy, fetch_ack, mem_en}), 32'b100);
      reset = 1'b1;
      tick();
      chk("t5_rst_ctrl", 32'({mem_en, mem_we, fetch_ack, data_ack, busy}), 32'd0);
      chk("t5_rst_data", 32'({mem_addr, mem_wdata, fetch_data, data_rdata}), 32'd0);
      reset = 1'b0;
      tick();
      chk("t5_reissue_en", 32'({mem_en, fetch_ack}), 32'b10);
      tick();
      tick();
      chk("t5_reissue_ack", 32'({fetch_ack, fetch_data}), 32'h1A5);
      fetch_req = 1'b0;
      tick();

      // Simultaneous requests: dropping after ack, then held continuously
      run_alt(1'b1, "alt_drop");
      run_alt(1'b0, "alt_held");
      tick();

      // Latency 3 data read on the second instance
      d3_data_addr = 12'h123; d3_data_we = 1'b0; d3_data_req = 1'b1;
      tick();
      chk("t4_en", 32'({d3_mem_en, d3_busy}), 32'b11);
      tick();
      chk("t4_busy2", 32'({d3_busy, d3_data_ack}), 32'b10);
      tick();
      chk("t4_busy3", 32'({d3_busy, d3_data_ack}), 32'b10);
      tick();
      chk("t4_busy4", 32'({d3_busy, d3_data_ack}), 32'b10);
      tick();
      chk("t4_ack5", 32'({d3_busy, d3_data_ack, d3_fetch_ack}), 32'b110);
      chk("t4_rdata", 32'(d3_data_rdata), 32'hC7);
      d3_data_req = 1'b0;
      tick();
      chk("t4_idle6", 32'({d3_busy, d3_data_ack}), 32'b00);

`ifdef MEM_ARB_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fetch_addr = 12'h010; data_addr = 12'h020; data_we = 1'b0;
      fetch_req = 1'b1; data_req = 1'b1;
      repeat (3) tick();
      chk("st_data_ack", 32'(data_ack), 32'd1);
      data_req = 1'b0;
      repeat (4) tick();
      chk("st_fetch_ack", 32'(fetch_ack), 32'd1);
      fetch_req = 1'b0;
      tick();
      chk("st_fetch_cnt", 32'(fetch_stall_cnt), 32'd4);
      chk("st_data_cnt", 32'(data_stall_cnt), 32'd0);
      force dut.fetch_stall_cnt = 16'hFFFF;
      tick();
      release dut.fetch_stall_cnt;
      fetch_req = 1'b1; data_req = 1'b1;
      repeat (3) tick();
      data_req = 1'b0;
      repeat (4) tick();
      fetch_req = 1'b0;
      tick();
      chk("st_saturate", 32'(fetch_stall_cnt), 32'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single external memory port shared by the processor's instruction fetch path and its data load/store path. It accepts level-held requests from both, serialises them onto one port with a fixed read latency, returns read data, and pulses a per-requester acknowledge. It sits between the control unit's fetch/memory-access sequencing and the external memory.

## Interface
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 12, memory address width
- MEM_LATENCY, 1, cycles from `mem_en` to valid `mem_rdata` (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- fetch_req  in  1  fetch read request, level
- fetch_addr  in  ADDR_WIDTH  fetch address
- fetch_ack  out  1  one-cycle completion pulse
- fetch_data  out  DATA_WIDTH  read word, valid while `fetch_ack`=1, held after
- data_req  in  1  data access request, level
- data_we  in  1  1=write, 0=read
- data_addr  in  ADDR_WIDTH  data address
- data_wdata  in  DATA_WIDTH  write word
- data_ack  out  1  one-cycle completion pulse
- data_rdata  out  DATA_WIDTH  read word, valid while `data_ack`=1, held after
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in every state except IDLE
- fetch_stall_cnt, data_stall_cnt  out  16  stall counters (only with macro)

## Operation
- FSM: IDLE → ISSUE → WAIT (reads only) → DONE → IDLE. All outputs registered.
- IDLE: sample requests. If exactly one is pending, grant it. If both are pending, grant data, unless `last_grant`=data, in which case grant fetch. Fetch is always a read.
- On grant: latch address, write enable and write data into internal registers, then go to ISSUE. Requester inputs are ignored until DONE.
- ISSUE: `mem_en`=1 with the latched fields. A write goes directly to DONE. A read loads the latency counter with MEM_LATENCY-1 and goes to WAIT.
- WAIT: decrement the counter. At 0, capture `mem_rdata` into the granted requester's data register and go to DONE.
- DONE: pulse the granted ack, update `last_grant`, ignore requests, return to IDLE.
- A requester must drop `req` in the cycle after it sees `ack`. A request still high in the IDLE cycle after DONE starts a new transaction.
- Reset: state=IDLE, `last_grant`=fetch (so the first simultaneous request goes to data). All outputs are 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both acks, both data registers, `busy`, and both counters. A reset mid-transaction abandons it with no ack; requesters reissue.

## Timing
- Request sampled high in IDLE at cycle T: `mem_en` at T+1.
- Write: ack at T+2. Back-to-back write throughput is 1 per 3 cycles.
- Read: `mem_rdata` sampled at T+1+MEM_LATENCY; ack and data at T+2+MEM_LATENCY. With MEM_LATENCY=1, ack at T+3.
- A losing requester waits for the full winner transaction plus the DONE cycle. Under alternation, worst-case fetch wait is one data transaction.
- `mem_en` is never high for two consecutive cycles.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - `fetch_stall_cnt` / `data_stall_cnt` increment each cycle the requester's `req`=1 and it is not the owner of the current transaction.
  - Counters saturate at 0xFFFF and clear on reset.
- Not defined: the counter ports and logic are absent.

## Structure
- Shared package holds:
  - FSM state enum {IDLE, ISSUE, WAIT, DONE}
  - grant-owner encoding {GNT_FETCH, GNT_DATA}
  - STALL_CNT_WIDTH=16
- Sub-module `mem_arb_latency_cnt`: loadable down-counter with a zero flag, sized by $clog2(MEM_LATENCY+1).

## Test plan
- fetch_req alone, addr 0x010, memory word 0xA5, MEM_LATENCY=1 -> `mem_en` at T+1 with `mem_addr`=0x010, `fetch_ack` and `fetch_data`=0xA5 at T+3, `data_ack` stays 0.
- data write addr 0xFFF, wdata 0x3C -> `mem_en`=`mem_we`=1 at T+1, `data_ack` at T+2, readback via data read returns 0x3C.
- Both requests asserted from reset and held, each requester dropping `req` after its ack -> grants in order data, fetch, data (alternation); no cycle has two acks.
- MEM_LATENCY=3, data read -> `data_ack` at T+5; `busy` high T+1..T+5.
- Reset asserted during WAIT -> next cycle all outputs 0, no ack. A request after reset completes normally.
- With `MEM_ARB_STATS_EN`, fetch held during one data read (MEM_LATENCY=1) -> `fetch_stall_cnt`=4. Forced saturation holds the counter at 0xFFFF.
